mem_arbiter: RTL

- Arbitrates the single-port unified RAM between the instruction-fetch requester (pipeline IF stage / icache side) and the data requester (MEM stage / dcache side).
- Sequences each RAM transaction with a small FSM, returns load data and a per-requester wait/hit handshake, and detects RAM error and timeout.
- Data requests have priority; a starvation counter guarantees fetch progress.
- Sits between the datapath's cache interface and the RAM model; one transaction is outstanding at a time.

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared by the cache-side datapath and the RAM arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT,
        DONE
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    function automatic logic [1:0] gnt_code(input arb_state_t s);
        logic [1:0] c;
        c = GNT_NONE;
        if (s == IGNT) c = GNT_I;
        if (s == DGNT) c = GNT_D;
        return c;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data requesters.
// Data wins by default; a streak counter bounds fetch starvation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err,
    output logic [1:0] gnt
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic [3:0] r_streak;
    logic [3:0] w_streak_nxt;
    logic [7:0] r_timer;
    logic [1:0] r_gnt;

    logic w_dreq;
    logic w_greq;
    logic w_granted;
    logic w_hit;
    logic w_fault;
    logic w_ihit;
    logic w_dhit;

    assign w_dreq    = dREN | dWEN;
    assign w_granted = (r_state == IGNT) || (r_state == DGNT);

    always_comb begin
        w_next       = r_state;
        w_streak_nxt = r_streak;
        w_greq       = 1'b0;
        w_hit        = 1'b0;
        w_fault      = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        unique case (r_state)
            IDLE: begin
                if (w_dreq && ((r_streak < STREAK_MAX) || !iREN)) begin
                    w_next = DGNT;
                    if (!iREN)
                        w_streak_nxt = '0;
                    else if (r_streak != 4'hF)
                        w_streak_nxt = r_streak + 4'd1;
                end else if (iREN) begin
                    w_next       = IGNT;
                    w_streak_nxt = '0;
                end
            end
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                w_greq  = iREN;
            end
            DGNT: begin
                // A write beats a read if both are raised together
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                w_greq   = w_dreq;
            end
            DONE: begin
                w_next = IDLE;
            end
        endcase

        if (w_granted) begin
            if (!w_greq) begin
                w_next = IDLE;
            end else if (ramstate == ACCESS) begin
                w_hit  = 1'b1;
                w_next = DONE;
            end else if (ramstate == ERROR || r_timer == TMO_LAST) begin
                w_fault = 1'b1;
                w_next  = DONE;
            end
        end
    end

    // A reset landing on the completing cycle must not leak a hit
    assign w_ihit = w_hit & (r_state == IGNT) & nRST;
    assign w_dhit = w_hit & (r_state == DGNT) & nRST;

    assign iwait = ~w_ihit;
    assign dwait = ~w_dhit;
    assign iload = w_ihit ? ramload : '0;
    assign dload = w_dhit ? ramload : '0;
    assign err   = w_fault & nRST;
    assign gnt   = r_gnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_timer  <= '0;
            r_gnt    <= GNT_NONE;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_nxt;
            r_gnt    <= gnt_code(w_next);
            r_timer  <= w_granted ? r_timer + 8'd1 : '0;
        end
    end

endmodule
